// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS bit-error-rate tester.
// The LFSR step is written on a 32-bit container so that any width up to 32 can reuse it.
package prbs_pkg;

    localparam int PRBS_N = 14;
    localparam logic [PRBS_N-1:0] PRBS_TAPS = 14'h2015;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DONE
    } state_e;

    // Shift left and append the XOR of the tapped bits; the caller truncates to its width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return {state[30:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/prbs_bert_ctrl_if.sv
// Control, link and status signals of the BERT controller, bundled for the register block.
interface prbs_bert_ctrl_if #(
    parameter int N  = 14,
    parameter int LW = 16,
    parameter int EW = 16
);
    logic          start;
    logic          abort;
    logic [N-1:0]  seed;
    logic [LW-1:0] len;
    logic          rx_bit;
    logic          rx_valid;
    logic          tx_bit;
    logic          tx_valid;
    logic          busy;
    logic          locked;
    logic          done;
    logic [EW-1:0] err_cnt;

    modport master (
        output start, abort, seed, len, rx_bit, rx_valid,
        input  tx_bit, tx_valid, busy, locked, done, err_cnt
    );

    modport slave (
        input  start, abort, seed, len, rx_bit, rx_valid,
        output tx_bit, tx_valid, busy, locked, done, err_cnt
    );
endinterface

// File: rtl/prbs_lfsr.sv
// Loadable LFSR that either runs on its own feedback or shifts in an external bit.
// The generator uses feedback; the checker uses the external input.
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int           N    = PRBS_N,
    parameter logic [N-1:0] TAPS = PRBS_TAPS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         shift_in_sel,
    input  logic         ext_bit,
    output logic [N-1:0] state,
    output logic         fb
);

    logic [N-1:0] state_q;
    logic [N-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (en) begin
            state_d = shift_in_sel ? {state_q[N-2:0], ext_bit}
                                   : N'(lfsr_next(32'(state_q), 32'(TAPS)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= N'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign fb    = ^(state_q & TAPS);

endmodule

// File: rtl/prbs_bert_ctrl.sv
// BERT controller: transmits a PRBS pattern, self-synchronises a checker to the received
// stream, counts mismatches over a programmed window and pulses done on completion.
module prbs_bert_ctrl
    import prbs_pkg::*;
#(
    parameter int           N    = PRBS_N,
    parameter logic [N-1:0] TAPS = PRBS_TAPS,
    parameter int           LW   = 16,
    parameter int           EW   = 16
) (
    input logic              clk,
    input logic              rst,
    prbs_bert_ctrl_if.slave  bus
);

    localparam int SW = $clog2(N + 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(N - 1);

    state_e        state_q,    state_d;
    logic [LW-1:0] len_q,      len_d;
    logic [LW-1:0] bit_cnt_q,  bit_cnt_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [EW-1:0] err_cnt_q,  err_cnt_d;

    logic          active;
    logic          accept_start;
    logic          chk_en;
    logic          chk_in;
    logic [N-1:0]  gen_state;
    logic          gen_fb;
    logic [N-1:0]  chk_state;
    logic          chk_fb;
    logic [N-1:0]  seed_eff;

    assign active       = (state_q == SYNC) || (state_q == RUN);
    assign accept_start = (state_q == IDLE) && bus.start && !bus.abort;
    assign seed_eff     = (bus.seed == '0) ? N'(1) : bus.seed;
    assign chk_en       = active && bus.rx_valid;
    // Once locked the checker follows its own prediction, so a flipped rx bit costs one error only.
    assign chk_in       = (state_q == RUN) ? chk_fb : bus.rx_bit;

    prbs_lfsr #(.N(N), .TAPS(TAPS)) u_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (accept_start),
        .load_val     (seed_eff),
        .en           (active),
        .shift_in_sel (1'b0),
        .ext_bit      (1'b0),
        .state        (gen_state),
        .fb           (gen_fb)
    );

    prbs_lfsr #(.N(N), .TAPS(TAPS)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .load         (1'b0),
        .load_val     ('0),
        .en           (chk_en),
        .shift_in_sel (1'b1),
        .ext_bit      (chk_in),
        .state        (chk_state),
        .fb           (chk_fb)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_d      = bus.len;
                        err_cnt_d  = '0;
                        sync_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (bus.rx_valid) begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_d = (len_q == '0) ? DONE : RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.rx_valid) begin
                        if ((bus.rx_bit != chk_fb) && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + EW'(1);
                        end
                        bit_cnt_d = bit_cnt_q + LW'(1);
                        if ((bit_cnt_q + LW'(1)) == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.tx_valid = active;
    assign bus.tx_bit   = active & gen_state[N-1];
    assign bus.busy     = (state_q != IDLE);
    assign bus.locked   = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.err_cnt  = err_cnt_q;

    logic unused_ok;
    assign unused_ok = ^{gen_fb, gen_state[N-2:0], chk_state};

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Directed-plus-random bench for prbs_bert_ctrl against a sequence-level reference model.
module tb_prbs_bert_ctrl;

    localparam int N        = 14;
    localparam int LW       = 16;
    localparam int EW       = 16;
    localparam int SAT_EW   = 4;
    localparam int SEQ_LEN  = 1200;
    localparam int TAPS_INT = 32'h2015;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    bit refSeq [SEQ_LEN];

    int           lockC, doneC, acc, txE, fa, fb2, fc, doneSeen;
    logic [N-1:0] txF, rs;

    prbs_bert_ctrl_if #(.N(N), .LW(LW), .EW(EW))     busIf ();
    prbs_bert_ctrl_if #(.N(N), .LW(LW), .EW(SAT_EW)) satIf ();

    prbs_bert_ctrl #(.N(N), .TAPS(14'h2015), .LW(LW), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    prbs_bert_ctrl #(.N(N), .TAPS(14'h2015), .LW(LW), .EW(SAT_EW)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (satIf.slave)
    );

    assign satIf.start    = busIf.start;
    assign satIf.abort    = busIf.abort;
    assign satIf.seed     = busIf.seed;
    assign satIf.len      = busIf.len;
    assign satIf.rx_bit   = busIf.rx_bit;
    assign satIf.rx_valid = busIf.rx_valid;

    always #5 clk = ~clk;

    // Expected transmit sequence: MSB of the state, then shift left with parity of the tapped bits.
    function automatic void buildSeq(input logic [N-1:0] seedIn);
        int s;
        s = (seedIn == '0) ? 1 : int'(seedIn);
        for (int i = 0; i < SEQ_LEN; i++) begin
            refSeq[i] = s[N-1];
            s = ((s << 1) | ($countones(s & TAPS_INT) % 2)) & ((1 << N) - 1);
        end
    endfunction

    task automatic applyStimulus(input logic st, input logic ab, input logic [N-1:0] sd,
                                 input logic [LW-1:0] ln);
        busIf.start = st;
        busIf.abort = ab;
        busIf.seed  = sd;
        busIf.len   = ln;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One test run. actKind: 0 none, 1 start pulse, 2 abort, 3 rst, applied in cycle actCycle.
    task automatic runTest(input logic [N-1:0] seedIn, input int lenIn, input bit gapMode,
                           input int flipA, input int flipB, input int flipC, input bit invertRun,
                           input int actCycle, input int actKind, input int expErr,
                           output int lockCycle, output int doneCycle, output int accepted,
                           output logic [N-1:0] txFirst, output int txErrs);
        int cyc, txIdx, runIdx;
        bit flip, fin;
        buildSeq(seedIn);
        lockCycle = -1; doneCycle = -1; accepted = 0; txFirst = '0; txErrs = 0;
        txIdx = 0; cyc = 0; fin = 0;
        busIf.rx_valid = 1'b0;
        busIf.rx_bit   = 1'b0;
        applyStimulus(1'b1, 1'b0, seedIn, LW'(lenIn));
        while (!fin && cyc < 1000) begin
            tick();
            cyc++;
            busIf.start = 1'b0;
            busIf.abort = 1'b0;
            if (actKind >= 2 && cyc == actCycle + 1) begin
                rst = 1'b0;
                checkOutput("act_busy",     int'(busIf.busy),     0);
                checkOutput("act_locked",   int'(busIf.locked),   0);
                checkOutput("act_tx_valid", int'(busIf.tx_valid), 0);
                checkOutput("act_tx_bit",   int'(busIf.tx_bit),   0);
                checkOutput("act_done",     int'(busIf.done),     0);
                checkOutput("act_err_cnt",  int'(busIf.err_cnt),  expErr);
                fin = 1;
            end else begin
                if (busIf.tx_valid) begin
                    if (txIdx < N) txFirst = {txFirst[N-2:0], busIf.tx_bit};
                    if (busIf.tx_bit !== refSeq[txIdx]) txErrs++;
                    txIdx++;
                end
                if (busIf.locked && lockCycle < 0) lockCycle = cyc;
                if (busIf.done) begin
                    doneCycle = cyc;
                    fin = 1;
                end else begin
                    if (cyc == actCycle) begin
                        if (actKind == 1) begin
                            busIf.start = 1'b1;
                            busIf.seed  = ~seedIn;
                        end
                        if (actKind == 2) busIf.abort = 1'b1;
                        if (actKind == 3) rst = 1'b1;
                    end
                    runIdx = accepted - N;
                    flip = (accepted >= N) &&
                           (invertRun || runIdx == flipA || runIdx == flipB || runIdx == flipC);
                    if (gapMode) begin
                        busIf.rx_valid = cyc[0];
                        busIf.rx_bit   = refSeq[accepted] ^ flip;
                    end else begin
                        busIf.rx_valid = busIf.tx_valid;
                        busIf.rx_bit   = busIf.tx_bit ^ flip;
                    end
                    if (busIf.rx_valid) accepted++;
                end
            end
        end
        busIf.rx_valid = 1'b0;
        busIf.rx_bit   = 1'b0;
        if (doneCycle > 0) tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        busIf.rx_valid = 1'b0;
        busIf.rx_bit   = 1'b0;
        repeat (2) tick();
        checkOutput("reset_flags", int'({busIf.busy, busIf.tx_valid, busIf.tx_bit,
                                         busIf.locked, busIf.done}), 0);
        checkOutput("reset_err_cnt", int'(busIf.err_cnt), 0);
        rst = 1'b0;
        tick();

        $display("[TB] seed 0x0001 pattern");
        runTest(14'h0001, 20, 0, -1, -1, -1, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("seed1_first14", int'(txF), 14'h0001);
        checkOutput("seed1_tx_seq", txE, 0);
        checkOutput("seed1_done_cycle", doneC, N + 20 + 1);

        $display("[TB] clean loopback, len 100");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 100, 0, -1, -1, -1, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("clean_lock_cycle", lockC, 15);
        checkOutput("clean_done_cycle", doneC, 115);
        checkOutput("clean_err_cnt", int'(busIf.err_cnt), 0);
        checkOutput("clean_tx_seq", txE, 0);
        checkOutput("clean_busy_after", int'(busIf.busy), 0);

        $display("[TB] error injection, len 200");
        fa  = $urandom_range(60, 0);
        fb2 = $urandom_range(130, 70);
        fc  = $urandom_range(199, 140);
        rs  = N'($urandom_range(16383, 1));
        runTest(rs, 200, 0, fa, fb2, fc, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("inject_err_cnt", int'(busIf.err_cnt), 3);
        checkOutput("inject_done_cycle", doneC, N + 200 + 1);

        $display("[TB] saturation, len 50 all inverted");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 50, 0, -1, -1, -1, 1, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("sat_wide_err_cnt", int'(busIf.err_cnt), 50);
        checkOutput("sat_narrow_err_cnt", int'(satIf.err_cnt), 15);

        $display("[TB] rx_valid gaps, len 20");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 20, 1, -1, -1, -1, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("gap_err_cnt", int'(busIf.err_cnt), 0);
        checkOutput("gap_accepted", acc, N + 20);
        checkOutput("gap_lock_cycle", lockC, 2 * N);
        checkOutput("gap_done_cycle", doneC, 2 * (N + 20));

        $display("[TB] start during RUN ignored");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 60, 0, 5, -1, -1, 0, 50, 1, 0, lockC, doneC, acc, txF, txE);
        checkOutput("restart_err_cnt", int'(busIf.err_cnt), 1);
        checkOutput("restart_done_cycle", doneC, N + 60 + 1);
        checkOutput("restart_tx_seq", txE, 0);

        $display("[TB] abort during RUN");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 100, 0, 2, 10, -1, 0, 60, 2, 2, lockC, doneC, acc, txF, txE);
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busIf.done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_err_hold", int'(busIf.err_cnt), 2);

        $display("[TB] rst during SYNC");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 100, 0, -1, -1, -1, 0, 5, 3, 0, lockC, doneC, acc, txF, txE);
        tick();

        $display("[TB] seed 0 acts as seed 1");
        runTest(14'h0000, 10, 0, -1, -1, -1, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("seed0_first14", int'(txF), 14'h0001);
        checkOutput("seed0_tx_seq", txE, 0);

        $display("[TB] len 0 skips RUN");
        rs = N'($urandom_range(16383, 1));
        runTest(rs, 0, 0, -1, -1, -1, 0, -1, 0, 0, lockC, doneC, acc, txF, txE);
        checkOutput("len0_lock_cycle", lockC, -1);
        checkOutput("len0_done_cycle", doneC, N + 1);

        $display("[TB] abort beats start in IDLE");
        applyStimulus(1'b1, 1'b1, 14'h0123, 16'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 14'h0123, 16'd5);
        checkOutput("abort_prio_busy", int'(busIf.busy), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
